// File: rtl/ex_muldiv_ctrl.sv
// EX-stage iterative 32-bit mul/div sequencer with load-use and HI/LO hazard control.
// Optional MTHI/MTLO write path is enabled by defining HILO_WRITE_EN.
module ex_muldiv_ctrl #(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MulDivStart_ex,
    input  logic [1:0]  MulDivOp_ex,
    input  logic [31:0] OpA_ex,
    input  logic [31:0] OpB_ex,
    input  logic        MemRead_ex,
    input  logic [4:0]  RegWriteAddr_ex,
    input  logic [4:0]  RsAddr_id,
    input  logic [4:0]  RtAddr_id,
    input  logic        MfHiLo_id,
    input  logic        MulDiv_id,
`ifdef HILO_WRITE_EN
    input  logic        MtHi_ex,
    input  logic        MtLo_ex,
`endif
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Stall,
    output logic        Flush_ex
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t      state, stateNext;
    logic [5:0]  count;
    logic        isDiv, isSigned, negA, negB, divZero;
    logic [31:0] accHi, accLo, operand, rawA;
    logic [31:0] absA, absB;
    logic [32:0] mulSum, divShift, divDiff;
    logic        divOk;
    logic [63:0] prod, mulRes;
    logic [31:0] quo, rem;
    logic        loadUse, hiloHaz;

    assign absA = (!MulDivOp_ex[0] && OpA_ex[31]) ? -OpA_ex : OpA_ex;
    assign absB = (!MulDivOp_ex[0] && OpB_ex[31]) ? -OpB_ex : OpB_ex;

    // Multiply step: add multiplicand into upper half, shift whole product right
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
    // Divide step: remainder:quotient shifted left, trial subtract divisor
    assign divShift = {accHi, accLo[31]};
    assign divDiff  = divShift - {1'b0, operand};
    assign divOk    = !divDiff[32];

    assign prod   = {accHi, accLo};
    assign mulRes = (isSigned && (negA ^ negB)) ? -prod : prod;
    assign quo    = (isSigned && (negA ^ negB)) ? -accLo : accLo;
    assign rem    = (isSigned && negA) ? -accHi : accHi;

    assign loadUse  = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                      ((RegWriteAddr_ex == RsAddr_id) ||
                       (RegWriteAddr_ex == RtAddr_id));
    assign hiloHaz  = Busy && (MfHiLo_id || MulDiv_id);
    assign Stall    = loadUse || hiloHaz;
    assign Flush_ex = Stall;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (MulDivStart_ex) stateNext = CALC;
            CALC:    if (count == 6'(CYCLES - 1)) stateNext = FIXUP;
            FIXUP:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 6'd0;
            Busy     <= 1'b0;
            Hi       <= 32'd0;
            Lo       <= 32'd0;
            isDiv    <= 1'b0;
            isSigned <= 1'b0;
            negA     <= 1'b0;
            negB     <= 1'b0;
            divZero  <= 1'b0;
            accHi    <= 32'd0;
            accLo    <= 32'd0;
            operand  <= 32'd0;
            rawA     <= 32'd0;
        end else begin
            state <= stateNext;
            Busy  <= (stateNext != IDLE);
            unique case (state)
                IDLE: begin
                    count <= 6'd0;
                    if (MulDivStart_ex) begin
                        isDiv    <= MulDivOp_ex[1];
                        isSigned <= !MulDivOp_ex[0];
                        negA     <= !MulDivOp_ex[0] && OpA_ex[31];
                        negB     <= !MulDivOp_ex[0] && OpB_ex[31];
                        divZero  <= (OpB_ex == 32'd0);
                        rawA     <= OpA_ex;
                        accHi    <= 32'd0;
                        accLo    <= MulDivOp_ex[1] ? absA : absB;
                        operand  <= MulDivOp_ex[1] ? absB : absA;
                    end
`ifdef HILO_WRITE_EN
                    if (MtHi_ex) Hi <= OpA_ex;
                    if (MtLo_ex) Lo <= OpA_ex;
`endif
                end
                CALC: begin
                    count <= count + 6'd1;
                    if (isDiv) begin
                        accHi <= divOk ? divDiff[31:0] : divShift[31:0];
                        accLo <= {accLo[30:0], divOk};
                    end else begin
                        accHi <= mulSum[32:1];
                        accLo <= {mulSum[0], accLo[31:1]};
                    end
                end
                FIXUP: begin
                    if (!isDiv) begin
                        Hi <= mulRes[63:32];
                        Lo <= mulRes[31:0];
                    end else if (divZero) begin
                        Hi <= rawA;
                        Lo <= 32'hFFFF_FFFF;
                    end else begin
                        Hi <= rem;
                        Lo <= quo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MulDivStart_ex;
    logic [1:0]  MulDivOp_ex;
    logic [31:0] OpA_ex, OpB_ex;
    logic        MemRead_ex;
    logic [4:0]  RegWriteAddr_ex, RsAddr_id, RtAddr_id;
    logic        MfHiLo_id, MulDiv_id;
    logic [31:0] Hi, Lo;
    logic        Busy, Stall, Flush_ex;
`ifdef HILO_WRITE_EN
    logic        MtHi_ex = 1'b0;
    logic        MtLo_ex = 1'b0;
`endif

    int nCmp = 0;
    int nErr = 0;

    ex_muldiv_ctrl #(.CYCLES(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MulDivStart_ex(MulDivStart_ex),
        .MulDivOp_ex(MulDivOp_ex),
        .OpA_ex(OpA_ex),
        .OpB_ex(OpB_ex),
        .MemRead_ex(MemRead_ex),
        .RegWriteAddr_ex(RegWriteAddr_ex),
        .RsAddr_id(RsAddr_id),
        .RtAddr_id(RtAddr_id),
        .MfHiLo_id(MfHiLo_id),
        .MulDiv_id(MulDiv_id),
`ifdef HILO_WRITE_EN
        .MtHi_ex(MtHi_ex),
        .MtLo_ex(MtLo_ex),
`endif
        .Hi(Hi),
        .Lo(Lo),
        .Busy(Busy),
        .Stall(Stall),
        .Flush_ex(Flush_ex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op and follows Busy until it falls (bounded at 40 cycles)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int bc,
                          output logic early);
        logic [31:0] h0, l0;
        h0 = Hi;
        l0 = Lo;
        bc = 0;
        early = 1'b0;
        MulDivOp_ex = op;
        OpA_ex = a;
        OpB_ex = b;
        MulDivStart_ex = 1'b1;
        tick();
        MulDivStart_ex = 1'b0;
        for (int i = 0; i < 40 && Busy; i++) begin
            bc++;
            if (Hi !== h0 || Lo !== l0) early = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nCmp++;
        if (Busy !== 1'b0) begin
            nErr++; $display("FAIL reset_busy got %b want 0", Busy);
        end
        nCmp++;
        if (Hi !== 32'd0 || Lo !== 32'd0) begin
            nErr++; $display("FAIL reset_hilo got %h:%h want 0:0", Hi, Lo);
        end
        nCmp++;
        if (Stall !== 1'b0 || Flush_ex !== 1'b0) begin
            nErr++; $display("FAIL reset_stall got %b/%b want 0/0", Stall, Flush_ex);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int bc;
        logic early;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, bc, early);
        nCmp++;
        if (bc !== 33) begin
            nErr++; $display("FAIL mult_busy_cycles got %0d want 33", bc);
        end
        nCmp++;
        if (early !== 1'b0) begin
            nErr++; $display("FAIL mult_hilo_early got %b want 0", early);
        end
        nCmp++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) begin
            nErr++; $display("FAIL mult_neg got %h:%h want ffffffff:fffffff1", Hi, Lo);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, early);
        nCmp++;
        if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
            nErr++; $display("FAIL multu_max got %h:%h want fffffffe:00000001", Hi, Lo);
        end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, bc, early);
        nCmp++;
        if (Hi !== 32'h4000_0000 || Lo !== 32'h0) begin
            nErr++; $display("FAIL mult_minmin got %h:%h want 40000000:00000000", Hi, Lo);
        end
    endtask

    task automatic test_divide();
        int bc;
        logic early;
        run_op(2'b11, 32'd100, 32'd7, bc, early);
        nCmp++;
        if (Hi !== 32'd2 || Lo !== 32'd14) begin
            nErr++; $display("FAIL divu_100_7 got %h:%h want 2:e", Hi, Lo);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc, early);
        nCmp++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFD) begin
            nErr++; $display("FAIL div_neg got %h:%h want ffffffff:fffffffd", Hi, Lo);
        end
        nCmp++;
        if (bc !== 33) begin
            nErr++; $display("FAIL div_busy_cycles got %0d want 33", bc);
        end
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, bc, early);
        nCmp++;
        if (Hi !== 32'd2 || Lo !== 32'hFFFF_FFF2) begin
            nErr++; $display("FAIL div_negdivisor got %h:%h want 2:fffffff2", Hi, Lo);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, early);
        nCmp++;
        if (Hi !== 32'd0 || Lo !== 32'h8000_0000) begin
            nErr++; $display("FAIL div_overflow got %h:%h want 0:80000000", Hi, Lo);
        end
    endtask

    task automatic test_div_zero();
        int bc;
        logic early;
        run_op(2'b10, 32'h1234, 32'd0, bc, early);
        nCmp++;
        if (Hi !== 32'h1234 || Lo !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL div_zero got %h:%h want 1234:ffffffff", Hi, Lo);
        end
        nCmp++;
        if (bc !== 33) begin
            nErr++; $display("FAIL div_zero_cycles got %0d want 33", bc);
        end
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, bc, early);
        nCmp++;
        if (Hi !== 32'hFFFF_FFF0 || Lo !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL div_zero_neg got %h:%h want fffffff0:ffffffff", Hi, Lo);
        end
        run_op(2'b11, 32'h8000_0005, 32'd0, bc, early);
        nCmp++;
        if (Hi !== 32'h8000_0005 || Lo !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL divu_zero got %h:%h want 80000005:ffffffff", Hi, Lo);
        end
    endtask

    task automatic test_load_use();
        MemRead_ex = 1'b1;
        RegWriteAddr_ex = 5'd5;
        RsAddr_id = 5'd3;
        RtAddr_id = 5'd5;
        #1;
        nCmp++;
        if (Stall !== 1'b1 || Flush_ex !== 1'b1) begin
            nErr++; $display("FAIL lu_rt got %b/%b want 1/1", Stall, Flush_ex);
        end
        tick();
        MemRead_ex = 1'b0;
        RegWriteAddr_ex = 5'd0;
        #1;
        nCmp++;
        if (Stall !== 1'b0 || Flush_ex !== 1'b0) begin
            nErr++; $display("FAIL lu_bubble got %b/%b want 0/0", Stall, Flush_ex);
        end
        MemRead_ex = 1'b1;
        RegWriteAddr_ex = 5'd9;
        RsAddr_id = 5'd9;
        RtAddr_id = 5'd1;
        #1;
        nCmp++;
        if (Stall !== 1'b1) begin
            nErr++; $display("FAIL lu_rs got %b want 1", Stall);
        end
        RegWriteAddr_ex = 5'd0;
        RsAddr_id = 5'd0;
        RtAddr_id = 5'd0;
        #1;
        nCmp++;
        if (Stall !== 1'b0 || Flush_ex !== 1'b0) begin
            nErr++; $display("FAIL lu_r0 got %b/%b want 0/0", Stall, Flush_ex);
        end
        RegWriteAddr_ex = 5'd7;
        RsAddr_id = 5'd6;
        RtAddr_id = 5'd8;
        #1;
        nCmp++;
        if (Stall !== 1'b0) begin
            nErr++; $display("FAIL lu_nomatch got %b want 0", Stall);
        end
        MemRead_ex = 1'b0;
        MfHiLo_id = 1'b1;
        MulDiv_id = 1'b1;
        #1;
        nCmp++;
        if (Stall !== 1'b0) begin
            nErr++; $display("FAIL hilo_idle got %b want 0", Stall);
        end
        MfHiLo_id = 1'b0;
        MulDiv_id = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int sc;
        logic flushBad, combBad;
        sc = 0;
        flushBad = 1'b0;
        combBad = 1'b0;
        MulDivOp_ex = 2'b01;
        OpA_ex = 32'd6;
        OpB_ex = 32'd7;
        MulDivStart_ex = 1'b1;
        tick();
        MulDivStart_ex = 1'b0;
        MfHiLo_id = 1'b1;
        #1;
        for (int i = 0; i < 40 && Stall; i++) begin
            sc++;
            if (Flush_ex !== Stall) flushBad = 1'b1;
            if (i == 10) begin
                MemRead_ex = 1'b1;
                RegWriteAddr_ex = 5'd4;
                RtAddr_id = 5'd4;
                MulDivStart_ex = 1'b1;
                MulDivOp_ex = 2'b11;
                OpA_ex = 32'd1;
                OpB_ex = 32'd1;
                #1;
                if (Stall !== 1'b1 || Flush_ex !== 1'b1) combBad = 1'b1;
            end
            tick();
            MemRead_ex = 1'b0;
            MulDivStart_ex = 1'b0;
        end
        nCmp++;
        if (sc !== 33) begin
            nErr++; $display("FAIL mflo_stall_cycles got %0d want 33", sc);
        end
        nCmp++;
        if (flushBad !== 1'b0 || combBad !== 1'b0) begin
            nErr++; $display("FAIL combined_stall got %b/%b want 0/0", flushBad, combBad);
        end
        nCmp++;
        if (Lo !== 32'd42 || Hi !== 32'd0 || Busy !== 1'b0) begin
            nErr++; $display("FAIL mflo_read got %h:%h busy %b want 0:2a busy 0", Hi, Lo, Busy);
        end
        MfHiLo_id = 1'b0;
        RtAddr_id = 5'd0;
        RegWriteAddr_ex = 5'd0;
        tick();
    endtask

    task automatic test_reset_mid();
        int bc;
        logic early;
        MulDivOp_ex = 2'b01;
        OpA_ex = 32'h1234_5678;
        OpB_ex = 32'd9;
        MulDivStart_ex = 1'b1;
        tick();
        MulDivStart_ex = 1'b0;
        repeat (10) tick();
        MulDiv_id = 1'b1;
        #1;
        nCmp++;
        if (Busy !== 1'b1 || Stall !== 1'b1) begin
            nErr++; $display("FAIL muldiv_id_hazard got %b/%b want 1/1", Busy, Stall);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nCmp++;
        if (Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || Stall !== 1'b0) begin
            nErr++; $display("FAIL reset_mid got busy %b %h:%h stall %b want 0 0:0 0", Busy, Hi, Lo, Stall);
        end
        MulDiv_id = 1'b0;
        run_op(2'b01, 32'd3, 32'd4, bc, early);
        nCmp++;
        if (Hi !== 32'd0 || Lo !== 32'd12 || bc !== 33) begin
            nErr++; $display("FAIL after_reset got %h:%h cyc %0d want 0:c cyc 33", Hi, Lo, bc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        MulDivStart_ex = 1'b0;
        MulDivOp_ex = 2'b00;
        OpA_ex = 32'd0;
        OpB_ex = 32'd0;
        MemRead_ex = 1'b0;
        RegWriteAddr_ex = 5'd0;
        RsAddr_id = 5'd0;
        RtAddr_id = 5'd0;
        MfHiLo_id = 1'b0;
        MulDiv_id = 1'b0;
        test_reset();
        test_mult();
        test_divide();
        test_div_zero();
        test_load_use();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
